// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. Results land in HI/LO
// after a fixed latency; busy lets the hazard unit stall dependent instructions.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic        out_sel,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [0:0]       state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_valid;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_zero;
    logic        div_ovf;

    // A zero divisor or the INT_MIN/-1 overflow is fed a divisor of 1; the
    // overflow case then yields exactly the required quotient 0x80000000, rem 0.
    always_comb begin
        div_zero = (in2 == 32'd0);
        div_ovf  = (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);
        div_b    = (div_zero || div_ovf) ? 32'd1 : in2;
        prod_s   = $signed({{32{in1[31]}}, in1}) * $signed({{32{in2[31]}}, in2});
        prod_u   = {32'd0, in1} * {32'd0, in2};
        quot_s   = $signed(in1) / $signed(div_b);
        rem_s    = $signed(in1) % $signed(div_b);
        quot_u   = in1 / div_b;
        rem_u    = in1 % div_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (mdu_op)
                            OP_MULT: begin
                                {res_hi, res_lo} <= prod_s;
                                res_valid        <= 1'b1;
                                counter          <= CNT_W'(MULT_CYCLES);
                                state            <= RUN;
                            end
                            OP_MULTU: begin
                                {res_hi, res_lo} <= prod_u;
                                res_valid        <= 1'b1;
                                counter          <= CNT_W'(MULT_CYCLES);
                                state            <= RUN;
                            end
                            OP_DIV: begin
                                res_hi    <= rem_s;
                                res_lo    <= quot_s;
                                res_valid <= !div_zero;
                                counter   <= CNT_W'(DIV_CYCLES);
                                state     <= RUN;
                            end
                            OP_DIVU: begin
                                res_hi    <= rem_u;
                                res_lo    <= quot_u;
                                res_valid <= !div_zero;
                                counter   <= CNT_W'(DIV_CYCLES);
                                state     <= RUN;
                            end
                            OP_MTHI: hi <= in1;
                            OP_MTLO: lo <= in1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Any start seen here is dropped; only the countdown advances.
                    if (counter == CNT_W'(1)) begin
                        if (res_valid) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign mdu_out = out_sel ? lo : hi;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, arithmetic results,
// HI/LO moves, reset during an operation and starts issued while busy.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        start;
    logic [2:0]  mdu_op;
    logic        out_sel;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int testsRun;
    int testsFailed;
    int cycles;

    localparam int LIMIT = 50;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .in1     (in1),
        .in2     (in2),
        .start   (start),
        .mdu_op  (mdu_op),
        .out_sel (out_sel),
        .busy    (busy),
        .mdu_out (mdu_out),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; pulses start across exactly one rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_op = op;
        in1    = a;
        in2    = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts negedges with busy high, bounded so a stuck busy cannot hang the run.
    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset   = 1'b1;
        start   = 1'b0;
        in1     = 32'd0;
        in2     = 32'd0;
        mdu_op  = 3'b000;
        out_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);

        // mult -2 * 3
        applyStimulus(3'b000, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_busy_rise", 64'(busy), 64'd1);
        waitIdle(cycles);
        checkOutput("mult_cycles", 64'(cycles), 64'd5);
        checkOutput("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // multu max * max
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitIdle(cycles);
        checkOutput("multu_cycles", 64'(cycles), 64'd5);
        checkOutput("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // div -7 / 2; HI still shows the old value while busy
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
        out_sel = 1'b0;
        #1;
        checkOutput("div_out_old", 64'(mdu_out), 64'hFFFF_FFFE);
        waitIdle(cycles);
        checkOutput("div_cycles", 64'(cycles), 64'd10);
        checkOutput("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // divu 100 / 7
        applyStimulus(3'b011, 32'd100, 32'd7);
        waitIdle(cycles);
        checkOutput("divu_cycles", 64'(cycles), 64'd10);
        checkOutput("divu_hilo", {hi, lo}, {32'd2, 32'd14});

        // divide by zero keeps HI/LO
        applyStimulus(3'b010, 32'd55, 32'd0);
        waitIdle(cycles);
        checkOutput("div0_cycles", 64'(cycles), 64'd10);
        checkOutput("div0_hilo", {hi, lo}, {32'd2, 32'd14});

        // signed overflow case
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(cycles);
        checkOutput("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        // mthi then mtlo on consecutive cycles
        applyStimulus(3'b100, 32'hDEAD_BEEF, 32'd0);
        checkOutput("mthi_busy", 64'(busy), 64'd0);
        applyStimulus(3'b101, 32'h1234_5678, 32'd0);
        checkOutput("mtlo_busy", 64'(busy), 64'd0);
        out_sel = 1'b0;
        #1;
        checkOutput("mfhi_out", 64'(mdu_out), 64'hDEAD_BEEF);
        out_sel = 1'b1;
        #1;
        checkOutput("mflo_out", 64'(mdu_out), 64'h1234_5678);

        // undefined op is a no-op
        applyStimulus(3'b110, 32'hAAAA_AAAA, 32'd1);
        checkOutput("undef_busy", 64'(busy), 64'd0);
        checkOutput("undef_hilo", {hi, lo}, 64'hDEAD_BEEF_1234_5678);

        // reset on the fourth busy cycle of a div
        applyStimulus(3'b011, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        checkOutput("midreset_discard", {hi, lo}, 64'd0);

        // reset wins over a simultaneous mthi
        reset = 1'b1;
        applyStimulus(3'b100, 32'h5555_5555, 32'd0);
        reset = 1'b0;
        checkOutput("reset_vs_start", 64'(hi), 64'd0);

        // second start while a mult is in flight is ignored
        applyStimulus(3'b000, 32'd6, 32'd7);
        applyStimulus(3'b101, 32'h7777_7777, 32'd0);
        waitIdle(cycles);
        checkOutput("busy_start_cycles", 64'(cycles + 1), 64'd5);
        checkOutput("busy_start_hilo", {hi, lo}, {32'd0, 32'd42});
        applyStimulus(3'b011, 32'd9, 32'd2);
        applyStimulus(3'b000, 32'd1000, 32'd1000);
        waitIdle(cycles);
        checkOutput("busy_start2_cycles", 64'(cycles + 1), 64'd10);
        checkOutput("busy_start2_hilo", {hi, lo}, {32'd1, 32'd4});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
